// File: rtl/vdu_mem_arbiter.sv
// vdu_mem_arbiter: shares one single-port synchronous display RAM between a
// CPU (level request / ack handshake) and a VDU fetch engine (single-cycle
// read pulses). The VDU has fixed priority; addresses outside the display
// window never reach the RAM but still complete on schedule.
// Optional feature: define VDU_ARB_STARVE_EN to bound the CPU wait to
// MAX_CPU_WAIT cycles by stalling the VDU for one cycle.
module vdu_mem_arbiter #(
    parameter logic [15:0] BASE_ADDR    = 16'h0200,
    parameter int          MEM_AW       = 9,
    parameter int          MAX_CPU_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [15:0]       cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic [7:0]        cpu_rdata,
    output logic              cpu_ack,
    input  logic              vdu_read_en,
    input  logic [15:0]       vdu_addr,
    output logic [7:0]        vdu_data_out,
    output logic              vdu_valid,
    output logic              vdu_stall,
    output logic              mem_en,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);

    localparam int WCW = (MAX_CPU_WAIT < 1) ? 1 : $clog2(MAX_CPU_WAIT + 1);
    localparam logic [WCW-1:0] WAIT_MAX = WCW'(MAX_CPU_WAIT);

    typedef enum logic {
        IDLE     = 1'b0,
        CPU_DATA = 1'b1
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [WCW-1:0]     wait_cnt;

    logic               cpu_grant;
    logic               vdu_grant;
    logic               starve;

    logic               cpu_in_win;
    logic               vdu_in_win;
    logic [MEM_AW-1:0]  cpu_off;
    logic [MEM_AW-1:0]  vdu_off;

    // Per-access bookkeeping captured at grant, consumed one cycle later.
    logic               cpu_rd_q;
    logic               cpu_oow_q;
    logic               vdu_oow_q;
    logic [7:0]         cpu_rdata_q;
    logic [7:0]         vdu_data_q;

    // True when addr lies in [BASE_ADDR, BASE_ADDR + 2**MEM_AW - 1]; the
    // 17-bit difference catches addresses below the base via its borrow bit.
    function automatic logic in_window(input logic [15:0] addr);
        logic [16:0] off;
        off = {1'b0, addr} - {1'b0, BASE_ADDR};
        return (off[16] == 1'b0) && ((off[15:0] >> MEM_AW) == 16'd0);
    endfunction

    assign cpu_in_win = in_window(cpu_addr);
    assign vdu_in_win = in_window(vdu_addr);
    assign cpu_off    = MEM_AW'(cpu_addr - BASE_ADDR);
    assign vdu_off    = MEM_AW'(vdu_addr - BASE_ADDR);

    // Arbitration: VDU first, unless the CPU has waited its limit.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
        cpu_grant = 1'b0;
        vdu_grant = 1'b0;
        starve    = 1'b0;
        // NOTE: grants are qualified by rst_n so mem_en drops the instant reset asserts, not at the next clock edge.
        if (rst_n) begin
`ifdef VDU_ARB_STARVE_EN
            starve = (state == IDLE) && cpu_req && (wait_cnt == WAIT_MAX);
`endif
            if (starve) begin
                cpu_grant = 1'b1;
            end else if (vdu_read_en) begin
                vdu_grant = 1'b1;
            end else if ((state == IDLE) && cpu_req) begin
                cpu_grant = 1'b1;
            end
        end
    end

    // State register: the cycle after a CPU grant is its data/ack cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: IDLE->CPU_DATA on a CPU grant; CPU_DATA always returns to IDLE.
    always_comb begin
        state_next = IDLE;
        case (state)
            IDLE:     state_next = cpu_grant ? CPU_DATA : IDLE;
            CPU_DATA: state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // Outputs: RAM port from the grant, handshakes and read-data steering.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = 8'h00;
        if (vdu_grant) begin
            mem_en   = vdu_in_win;
            mem_addr = vdu_off;
        end else if (cpu_grant) begin
            mem_en    = cpu_in_win;
            mem_we    = cpu_we && cpu_in_win;
            mem_addr  = cpu_off;
            mem_wdata = cpu_wdata;
        end

        cpu_ack   = (state == CPU_DATA);
        vdu_stall = starve && vdu_read_en;

        cpu_rdata = cpu_rdata_q;
        if (cpu_ack && cpu_rd_q) begin
            cpu_rdata = cpu_oow_q ? 8'hFF : mem_rdata;
        end

        vdu_data_out = vdu_data_q;
        if (vdu_valid) begin
            vdu_data_out = vdu_oow_q ? 8'h00 : mem_rdata;
        end
    end

    // CPU wait counter: counts refused IDLE cycles, saturating, cleared on grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (cpu_grant) begin
            wait_cnt <= '0;
        end else if (cpu_req && (state == IDLE) && (wait_cnt != WAIT_MAX)) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Access bookkeeping and held read data for both requesters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_rd_q    <= 1'b0;
            cpu_oow_q   <= 1'b0;
            vdu_oow_q   <= 1'b0;
            vdu_valid   <= 1'b0;
            cpu_rdata_q <= 8'h00;
            vdu_data_q  <= 8'h00;
        end else begin
            if (cpu_grant) begin
                cpu_rd_q  <= !cpu_we;
                cpu_oow_q <= !cpu_in_win;
            end
            if (vdu_grant) begin
                vdu_oow_q <= !vdu_in_win;
            end
            vdu_valid   <= vdu_grant;
            cpu_rdata_q <= cpu_rdata;
            vdu_data_q  <= vdu_data_out;
        end
    end

endmodule
